// File: rtl/hwacc_mmio_responder_pkg.sv
// Shared constants for the accelerator MMIO responder: region code, register
// indices and CTRL/STATUS bit positions.
package hwacc_pkg;

    localparam logic [1:0] REGION_ACC = 2'b01;

    typedef enum logic [5:0] {
        IDX_CTRL     = 6'd0,
        IDX_STATUS   = 6'd1,
        IDX_IN_DATA  = 6'd2,
        IDX_OUT_DATA = 6'd3,
        IDX_OUT_POP  = 6'd4,
        IDX_SCRATCH  = 6'd5
    } reg_idx_e;

    localparam int CTRL_START_BIT      = 0;
    localparam int CTRL_CLEAR_BIT      = 1;
    localparam int CTRL_CLR_STICKY_BIT = 2;

    localparam int ST_IN_COUNT_LSB  = 0;
    localparam int ST_OUT_COUNT_LSB = 8;
    localparam int ST_IN_FULL       = 16;
    localparam int ST_IN_EMPTY      = 17;
    localparam int ST_OUT_FULL      = 18;
    localparam int ST_OUT_EMPTY     = 19;
    localparam int ST_IN_OVERFLOW   = 20;
    localparam int ST_OUT_UNDERFLOW = 21;
    localparam int ST_ACC_BUSY      = 22;

    function automatic logic region_hit(input logic [1:0] region);
        return region == REGION_ACC;
    endfunction

endpackage

// File: rtl/hwacc_mmio_responder_if.sv
// CPU memory-port and accelerator handshake signals of the MMIO responder.
interface hwacc_mmio_responder_if #(
    parameter int D_WIDTH    = 64,
    parameter int ADDR_WIDTH = 10
);
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [D_WIDTH-1:0]    mem_wdata;
    logic                  mem_we;
    logic [D_WIDTH-1:0]    mem_rdata;

    logic                  acc_in_valid;
    logic [D_WIDTH-1:0]    acc_in_data;
    logic                  acc_in_ready;
    logic                  acc_out_valid;
    logic [D_WIDTH-1:0]    acc_out_data;
    logic                  acc_out_ready;
    logic                  acc_start;
    logic                  acc_busy;

    modport slave (
        input  mem_addr, mem_wdata, mem_we,
        input  acc_in_ready, acc_out_valid, acc_out_data, acc_busy,
        output mem_rdata, acc_in_valid, acc_in_data, acc_out_ready, acc_start
    );

    modport master (
        output mem_addr, mem_wdata, mem_we,
        output acc_in_ready, acc_out_valid, acc_out_data, acc_busy,
        input  mem_rdata, acc_in_valid, acc_in_data, acc_out_ready, acc_start
    );
endinterface

// File: rtl/hwacc_sync_fifo.sv
// Single-clock FIFO with combinational head, clear-wins semantics and
// push-while-full accepted when a pop happens in the same cycle.
module hwacc_sync_fifo #(
    parameter int DWIDTH = 64,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr,
    input  logic [DWIDTH-1:0]          din,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic [DWIDTH-1:0]          head
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              pop_ok, push_ok;

    assign empty  = (count_q == '0);
    assign full   = (count_q == CW'(DEPTH));
    assign count  = count_q;
    assign head   = mem_q[rd_ptr_q];

    assign pop_ok  = pop & ~empty & ~clr;
    assign push_ok = push & (~full | pop_ok) & ~clr;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: stale entries are unreachable once count is 0.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/hwacc_mmio_responder.sv
// MMIO responder on the datapath memory port: CTRL/STATUS/SCRATCH registers
// plus an input and an output FIFO towards the hardware accelerator.
module hwacc_mmio_responder
    import hwacc_pkg::*;
#(
    parameter int D_WIDTH    = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    hwacc_mmio_responder_if.slave  bus
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic               hit;
    reg_idx_e           idx;
    logic               wr_en, wr_ctrl, wr_in, wr_pop, wr_scratch;
    logic               soft_clr, clr_sticky;

    logic               in_full, in_empty, out_full, out_empty;
    logic [CW-1:0]      in_count, out_count;
    logic [D_WIDTH-1:0] in_head, out_head;
    logic               in_pop, out_push;

    logic [D_WIDTH-1:0] rdata_q, rdata_d;
    logic [D_WIDTH-1:0] scratch_q, scratch_d;
    logic               start_q, start_d;
    logic               in_ovf_q, in_ovf_d;
    logic               out_udf_q, out_udf_d;
    logic [D_WIDTH-1:0] status_word;

    assign hit        = region_hit(bus.mem_addr[9:8]);
    assign idx        = reg_idx_e'(bus.mem_addr[7:2]);
    assign wr_en      = bus.mem_we & hit;
    assign wr_ctrl    = wr_en & (idx == IDX_CTRL);
    assign wr_in      = wr_en & (idx == IDX_IN_DATA);
    assign wr_pop     = wr_en & (idx == IDX_OUT_POP);
    assign wr_scratch = wr_en & (idx == IDX_SCRATCH);
    assign soft_clr   = wr_ctrl & bus.mem_wdata[CTRL_CLEAR_BIT];
    assign clr_sticky = wr_ctrl & bus.mem_wdata[CTRL_CLR_STICKY_BIT];

    assign in_pop   = ~in_empty & bus.acc_in_ready;
    assign out_push = bus.acc_out_valid & ~out_full;

    hwacc_sync_fifo #(.DWIDTH(D_WIDTH), .DEPTH(FIFO_DEPTH)) u_in_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (wr_in),
        .pop     (in_pop),
        .clr     (soft_clr),
        .din     (bus.mem_wdata),
        .full    (in_full),
        .empty   (in_empty),
        .count   (in_count),
        .head    (in_head)
    );

    hwacc_sync_fifo #(.DWIDTH(D_WIDTH), .DEPTH(FIFO_DEPTH)) u_out_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (out_push),
        .pop     (wr_pop),
        .clr     (soft_clr),
        .din     (bus.acc_out_data),
        .full    (out_full),
        .empty   (out_empty),
        .count   (out_count),
        .head    (out_head)
    );

    assign bus.acc_in_valid  = ~in_empty;
    assign bus.acc_in_data   = in_head;
    assign bus.acc_out_ready = ~out_full;
    assign bus.acc_start     = start_q;
    assign bus.mem_rdata     = rdata_q;

    always_comb begin
        status_word = '0;
        status_word[ST_IN_COUNT_LSB  +: 8] = 8'(in_count);
        status_word[ST_OUT_COUNT_LSB +: 8] = 8'(out_count);
        status_word[ST_IN_FULL]       = in_full;
        status_word[ST_IN_EMPTY]      = in_empty;
        status_word[ST_OUT_FULL]      = out_full;
        status_word[ST_OUT_EMPTY]     = out_empty;
        status_word[ST_IN_OVERFLOW]   = in_ovf_q;
        status_word[ST_OUT_UNDERFLOW] = out_udf_q;
        status_word[ST_ACC_BUSY]      = bus.acc_busy;
    end

    // Read data is taken from pre-update state, so same-cycle pushes are not yet visible.
    always_comb begin
        rdata_d = '0;
        if (hit) begin
            case (idx)
                IDX_STATUS:   rdata_d = status_word;
                IDX_OUT_DATA: rdata_d = out_empty ? '0 : out_head;
                IDX_SCRATCH:  rdata_d = scratch_q;
                default:      rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        scratch_d = wr_scratch ? bus.mem_wdata : scratch_q;
        start_d   = wr_ctrl & bus.mem_wdata[CTRL_START_BIT] & ~bus.mem_wdata[CTRL_CLEAR_BIT];
        in_ovf_d  = in_ovf_q;
        out_udf_d = out_udf_q;
        if (soft_clr | clr_sticky) begin
            in_ovf_d  = 1'b0;
            out_udf_d = 1'b0;
        end else begin
            if (wr_in & in_full & ~in_pop) in_ovf_d  = 1'b1;
            if (wr_pop & out_empty)        out_udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata_q   <= '0;
            scratch_q <= '0;
            start_q   <= 1'b0;
            in_ovf_q  <= 1'b0;
            out_udf_q <= 1'b0;
        end else begin
            rdata_q   <= rdata_d;
            scratch_q <= scratch_d;
            start_q   <= start_d;
            in_ovf_q  <= in_ovf_d;
            out_udf_q <= out_udf_d;
        end
    end

endmodule

// File: tb/tb_hwacc_mmio_responder.sv
// Scoreboard bench for hwacc_mmio_responder: register reads are queued with
// their expected value when driven and compared when mem_rdata returns.
module tb_hwacc_mmio_responder;

    localparam int DW    = 64;
    localparam int AW    = 10;
    localparam int DEPTH = 8;

    logic clk;
    logic reset_n;

    hwacc_mmio_responder_if #(.D_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    hwacc_mmio_responder #(.D_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [DW-1:0] sb_exp [$];
    string         sb_tag [$];

    task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("pass %s: %h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.mem_addr  = a;
        bus.mem_wdata = d;
        bus.mem_we    = 1'b1;
        tick();
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
        bus.mem_addr = a;
        bus.mem_we   = 1'b0;
        sb_exp.push_back(exp);
        sb_tag.push_back(tag);
        tick();
        check_val(sb_tag.pop_front(), bus.mem_rdata, sb_exp.pop_front());
    endtask

    function automatic logic [DW-1:0] st(input int ic, input int oc, input bit ovf,
                                         input bit udf, input bit busy);
        logic [DW-1:0] w;
        w = DW'(ic) | (DW'(oc) << 8);
        w[16] = (ic == DEPTH);
        w[17] = (ic == 0);
        w[18] = (oc == DEPTH);
        w[19] = (oc == 0);
        w[20] = ovf;
        w[21] = udf;
        w[22] = busy;
        return w;
    endfunction

    task automatic acc_push(input logic [DW-1:0] d);
        bus.acc_out_valid = 1'b1;
        bus.acc_out_data  = d;
        tick();
        bus.acc_out_valid = 1'b0;
    endtask

    initial begin
        reset_n           = 1'b0;
        bus.mem_addr      = '0;
        bus.mem_wdata     = '0;
        bus.mem_we        = 1'b0;
        bus.acc_in_ready  = 1'b0;
        bus.acc_out_valid = 1'b0;
        bus.acc_out_data  = '0;
        bus.acc_busy      = 1'b0;
        #1;
        check_val("rst_rdata", bus.mem_rdata, '0);
        check_val("rst_start", DW'(bus.acc_start), '0);
        check_val("rst_in_valid", DW'(bus.acc_in_valid), '0);
        check_val("rst_out_ready", DW'(bus.acc_out_ready), DW'(1));
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        rd("status_reset", 10'h104, 64'h000A_0000);

        // Two input words, then drain them with acc_in_ready.
        wr(10'h108, 64'hDEAD_BEEF_0000_0001);
        wr(10'h108, 64'hDEAD_BEEF_0000_0002);
        rd("status_in2", 10'h104, st(2, 0, 0, 0, 0));
        check_val("in_valid_2", DW'(bus.acc_in_valid), DW'(1));
        check_val("in_head_1", bus.acc_in_data, 64'hDEAD_BEEF_0000_0001);
        bus.acc_in_ready = 1'b1;
        tick();
        check_val("in_head_2", bus.acc_in_data, 64'hDEAD_BEEF_0000_0002);
        tick();
        bus.acc_in_ready = 1'b0;
        check_val("in_valid_drained", DW'(bus.acc_in_valid), '0);

        // Overflow, sticky clear, soft clear.
        for (int i = 0; i < DEPTH + 1; i++) wr(10'h108, DW'(i));
        rd("status_ovf", 10'h104, st(8, 0, 1, 0, 0));
        wr(10'h100, 64'h4);
        rd("status_clr_sticky", 10'h104, st(8, 0, 0, 0, 0));
        wr(10'h100, 64'h2);
        rd("status_soft_clr", 10'h104, st(0, 0, 0, 0, 0));

        // Push while full with a simultaneous pop: both accepted.
        for (int i = 0; i < DEPTH; i++) wr(10'h108, 64'h100 + DW'(i));
        bus.acc_in_ready = 1'b1;
        wr(10'h108, 64'h1FF);
        bus.acc_in_ready = 1'b0;
        rd("status_full_pushpop", 10'h104, st(8, 0, 0, 0, 0));
        check_val("in_head_after_pushpop", bus.acc_in_data, 64'h101);
        wr(10'h100, 64'h2);

        // Output FIFO: peek, pop, underflow; STATUS read shows pre-push count.
        acc_push(64'h11);
        acc_push(64'h22);
        bus.acc_out_valid = 1'b1;
        bus.acc_out_data  = 64'h33;
        rd("status_same_cycle_push", 10'h104, st(0, 2, 0, 0, 0));
        bus.acc_out_valid = 1'b0;
        rd("status_out3", 10'h104, st(0, 3, 0, 0, 0));
        rd("out_peek_a", 10'h10C, 64'h11);
        rd("out_peek_b", 10'h10C, 64'h11);
        wr(10'h110, '0);
        rd("out_after_pop", 10'h10C, 64'h22);
        wr(10'h110, '0);
        wr(10'h110, '0);
        rd("out_empty_data", 10'h10C, '0);
        wr(10'h110, '0);
        rd("status_udf", 10'h104, st(0, 0, 0, 1, 0));

        // Soft clear in the same cycle as an accelerator push: clear wins.
        bus.acc_out_valid = 1'b1;
        bus.acc_out_data  = 64'h44;
        wr(10'h100, 64'h2);
        bus.acc_out_valid = 1'b0;
        rd("status_clr_vs_push", 10'h104, st(0, 0, 0, 0, 0));

        for (int i = 0; i < DEPTH; i++) acc_push(64'h200 + DW'(i));
        check_val("out_ready_full", DW'(bus.acc_out_ready), '0);
        rd("status_out_full", 10'h104, st(0, 8, 0, 0, 0));

        // Start and clear together: clear only.
        wr(10'h108, 64'h55);
        wr(10'h100, 64'h3);
        check_val("start_suppressed", DW'(bus.acc_start), '0);
        rd("status_after_ctrl3", 10'h104, st(0, 0, 0, 0, 0));

        wr(10'h100, 64'h1);
        check_val("start_pulse", DW'(bus.acc_start), DW'(1));
        tick();
        check_val("start_one_cycle", DW'(bus.acc_start), '0);

        // Region decode.
        wr(10'h014, 64'h77);
        wr(10'h008, 64'h1);
        wr(10'h214, 64'h66);
        wr(10'h308, 64'h9);
        rd("scratch_untouched", 10'h114, '0);
        rd("status_region0", 10'h104, st(0, 0, 0, 0, 0));
        wr(10'h114, 64'h5A);
        rd("scratch_rb", 10'h117, 64'h5A);
        rd("reserved_alias", 10'h314, '0);
        rd("reserved_200", 10'h200, '0);
        rd("ctrl_reads0", 10'h100, '0);
        rd("in_data_reads0", 10'h108, '0);
        rd("unmapped", 10'h13C, '0);
        bus.acc_busy = 1'b1;
        rd("status_busy", 10'h104, st(0, 0, 0, 0, 1));
        bus.acc_busy = 1'b0;

        // Asynchronous reset with traffic in both FIFOs.
        for (int i = 0; i < 3; i++) wr(10'h108, 64'h300 + DW'(i));
        for (int i = 0; i < 3; i++) acc_push(64'h400 + DW'(i));
        rd("status_pre_reset", 10'h104, st(3, 3, 0, 0, 0));
        rd("scratch_pre_reset", 10'h114, 64'h5A);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("async_in_valid", DW'(bus.acc_in_valid), '0);
        check_val("async_rdata", bus.mem_rdata, '0);
        tick();
        tick();
        reset_n = 1'b1;
        rd("status_post_reset", 10'h104, st(0, 0, 0, 0, 0));
        rd("scratch_post_reset", 10'h114, '0);

        if (sb_exp.size() != 0) begin
            err_cnt++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_exp.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/hwacc_mmio_responder.md
Name: hwacc_mmio_responder

Overview:
- Target-side responder for the RISC-V datapath's external memory port (mem_addr_out / mem_data_out / mem_we / mem_datat_in).
- Claims every access with addr[9:8] != 0 and exposes control/status registers plus two FIFOs to the hardware accelerator: an input FIFO (CPU pushes, accelerator drains) and an output FIFO (accelerator fills, CPU pops).
- Accesses with addr[9:8] == 0 belong to the internal d_mem and are ignored entirely.

Parameters:
- D_WIDTH, 64, data word width on both CPU and accelerator sides.
- ADDR_WIDTH, 10, CPU byte address width.
- FIFO_DEPTH, 8, entries per FIFO; must be a power of two, 2..128.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous, active-low reset.
- mem_addr  in  ADDR_WIDTH  byte address from the datapath, valid every cycle.
- mem_wdata  in  D_WIDTH  store data.
- mem_we  in  1  store strobe; qualified internally with addr[9:8] != 0.
- mem_rdata  out  D_WIDTH  registered read data, returned to the datapath one cycle later.
- acc_in_valid  out  1  input FIFO not empty.
- acc_in_data  out  D_WIDTH  input FIFO head.
- acc_in_ready  in  1  accelerator consumes the head this cycle.
- acc_out_valid  in  1  accelerator presents a result.
- acc_out_data  in  D_WIDTH  result word.
- acc_out_ready  out  1  output FIFO not full.
- acc_start  out  1  one-cycle start pulse.
- acc_busy  in  1  accelerator status, mirrored into STATUS.

Behaviour:
- Decode uses reg index = addr[7:2] when addr[9:8] == 2'b01. Regions 2'b10 and 2'b11 are reserved: reads return 0 and writes are ignored. Byte offset addr[1:0] is ignored.
- Register map (byte address):
  - 0x100 CTRL (write only). bit0 = start, producing an acc_start pulse in the cycle after the write. bit1 = soft clear, which empties both FIFOs and clears sticky flags. bit2 = clear sticky flags only. Reads return 0.
  - 0x104 STATUS (read only). [7:0] in_count, [15:8] out_count, 16 in_full, 17 in_empty, 18 out_full, 19 out_empty, 20 in_overflow (sticky), 21 out_underflow (sticky), 22 acc_busy. Other bits 0.
  - 0x108 IN_DATA. A write pushes mem_wdata into the input FIFO. Reads return 0.
  - 0x10C OUT_DATA. A read returns the output FIFO head without popping. Returns 0 if empty.
  - 0x110 OUT_POP. Any write pops the output FIFO.
  - 0x114 SCRATCH. 64-bit read/write register, reset 0.
  - Unmapped indices read 0.
- Read timing:
  - mem_rdata is registered every clock from the current mem_addr, with no read strobe.
  - Reads are side-effect free.
  - Data reflects state before any same-cycle updates, so a STATUS read in the same cycle as a push shows the old count.
- Accelerator handshakes:
  - Input FIFO pops when acc_in_valid & acc_in_ready.
  - Output FIFO pushes when acc_out_valid & acc_out_ready.
- Boundary conditions:
  - Push to IN_DATA while in_full: word dropped, in_overflow set.
  - Write to OUT_POP while out_empty: no-op, out_underflow set.
  - Simultaneous push and pop on the same FIFO: both occur and the count is unchanged. When full, a pop and a push in the same cycle are both accepted.
  - Soft clear in the same cycle as any push or pop: clear wins. Counts become 0 next cycle and acc_start is not asserted.
  - CTRL write with bits 0 and 1 both set: clear performed, start suppressed.
  - Pointers wrap modulo FIFO_DEPTH. Counts saturate at FIFO_DEPTH by construction.
- Reset (asynchronous assert, clocked deassert):
  - mem_rdata = 0, acc_start = 0, FIFOs empty, so acc_in_valid = 0 and acc_out_ready = 1.
  - Sticky flags = 0, SCRATCH = 0.
  - Reset mid-transfer discards all FIFO contents.

Decomposition:
- Shared package hwacc_pkg holds:
  - Region code 2'b01.
  - Register index constants: CTRL=0, STATUS=1, IN_DATA=2, OUT_DATA=3, OUT_POP=4, SCRATCH=5.
  - STATUS and CTRL bit positions.
- One sub-module, hwacc_sync_fifo (parameters DWIDTH, DEPTH):
  - Ports: push, pop, clr, full, empty, count, head.
  - Instantiated twice.
- Top level contains decode, registers, sticky logic and the read mux.

Test Plan:
- Reset, then read 0x104 → mem_rdata one cycle later = 0x000A_0000 (in_empty, out_empty set), acc_out_ready=1, acc_in_valid=0.
- Write 0x108 with 0xDEAD_BEEF_0000_0001 then 0x...0002, acc_in_ready=0 → in_count=2, acc_in_data=...0001. Raise acc_in_ready for 2 cycles → acc_in_data sequence 0001, 0002, then acc_in_valid=0.
- With acc_in_ready=0, write IN_DATA 9 times → STATUS in_count=8, in_full=1, in_overflow=1. Write CTRL=0x4 → overflow=0, count still 8. Write CTRL=0x2 → in_count=0.
- Accelerator pushes 0x11, 0x22 → read 0x10C returns 0x11 twice (non-destructive). Write 0x110, read 0x10C → 0x22. Pop twice → out_underflow=1.
- Write CTRL=0x1 → acc_start high exactly one cycle. Write CTRL=0x3 → no pulse, FIFOs cleared. Write mem_we at 0x008 (region 0) → no state change. Write SCRATCH=0x5A, read back 0x5A. Read 0x200 → 0.
- Assert reset_n=0 mid-stream with 3 words in each FIFO → immediately acc_in_valid=0, mem_rdata=0. After release, STATUS counts = 0.
